// File: rtl/sha3_sponge_ctrl.sv
// Control sequencer for a Keccak-f[1600] sponge: command latch, block absorb,
// padding, permutation handshake and squeeze beat generation. Holds no sponge state.
module sha3_sponge_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_mode_i,
    input  logic [12:0] cmd_out_len_i,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    input  logic [7:0]  blk_len_i,
    input  logic        blk_last_i,
    output logic        state_clr_o,
    output logic        absorb_en_o,
    output logic [7:0]  absorb_len_o,
    output logic        pad_en_o,
    output logic [7:0]  pad_pos_o,
    output logic [7:0]  domain_o,
    output logic [7:0]  rate_bytes_o,
    output logic        perm_start_o,
    input  logic        perm_done_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [10:0] out_len_o,
    output logic        out_last_o,
    output logic [1:0]  mode_out_o,
    output logic        err_o
);

    localparam int unsigned REM_W      = 13;
    localparam int unsigned OLEN_W     = 11;
    localparam logic [7:0]  R_SHAKE128 = 8'd168;
    localparam logic [7:0]  R_SHAKE256 = 8'd136;
    localparam logic [7:0]  R_SHA3_256 = 8'd136;
    localparam logic [7:0]  R_SHA3_512 = 8'd72;
    localparam logic [7:0]  DS_SHAKE   = 8'h1F;
    localparam logic [7:0]  DS_SHA3    = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_WAIT_BLK, S_ABSORB, S_PSTART, S_PWAIT, S_PAD, S_SQUEEZE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         rate_q, rate_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [7:0]         len_q, len_d;
    logic               last_q, last_d;
    logic               padded_q, padded_d;
    logic               sqp_q, sqp_d;
    logic               act_q, act_d;

    logic               cmd_ready_d, blk_ready_d, state_clr_d, absorb_en_d;
    logic [7:0]         absorb_len_d, pad_pos_d, domain_d;
    logic               pad_en_d, perm_start_d, out_valid_d, out_last_d, err_d;
    logic [OLEN_W-1:0]  out_len_d;
    logic [OLEN_W-1:0]  rate_bits_d;

    function automatic logic [7:0] rate_of(input logic [1:0] m);
        case (m)
            2'b00:   return R_SHAKE128;
            2'b01:   return R_SHAKE256;
            2'b10:   return R_SHA3_256;
            default: return R_SHA3_512;
        endcase
    endfunction

    // Next-state logic, then registered outputs decoded from the next state
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rate_d   = rate_q;
        rem_d    = rem_q;
        len_d    = len_q;
        last_d   = last_q;
        padded_d = padded_q;
        sqp_d    = sqp_q;
        act_d    = act_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    mode_d   = cmd_mode_i;
                    rate_d   = rate_of(cmd_mode_i);
                    rem_d    = cmd_mode_i[1] ? (cmd_mode_i[0] ? REM_W'(512) : REM_W'(256))
                                             : cmd_out_len_i;
                    last_d   = 1'b0;
                    padded_d = 1'b0;
                    sqp_d    = 1'b0;
                    act_d    = 1'b1;
                    state_d  = S_CLR;
                end
            end
            S_CLR: state_d = S_WAIT_BLK;
            S_WAIT_BLK: begin
                if (blk_valid_i && blk_ready_o) begin
                    if (blk_len_i > rate_q) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = blk_len_i;
                        last_d   = blk_last_i;
                        padded_d = blk_last_i && (blk_len_i < rate_q);
                        state_d  = S_ABSORB;
                    end
                end
            end
            S_ABSORB: state_d = S_PSTART;
            S_PSTART: state_d = S_PWAIT;
            S_PWAIT: begin
                if (perm_done_i) begin
                    if (sqp_q || (last_q && padded_q)) state_d = S_SQUEEZE;
                    else if (last_q)                   state_d = S_PAD;
                    else                               state_d = S_WAIT_BLK;
                end
            end
            S_PAD: begin
                padded_d = 1'b1;
                state_d  = S_PSTART;
            end
            S_SQUEEZE: begin
                if (out_valid_o && out_ready_i) begin
                    rem_d = rem_q - REM_W'(out_len_o);
                    if (out_last_o) begin
                        state_d = S_IDLE;
                    end else begin
                        sqp_d   = 1'b1;
                        state_d = S_PSTART;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rate_bits_d  = {rate_d, 3'b000};
        cmd_ready_d  = (state_d == S_IDLE);
        blk_ready_d  = (state_d == S_WAIT_BLK);
        state_clr_d  = (state_d == S_CLR);
        absorb_en_d  = (state_d == S_ABSORB) || (state_d == S_PAD);
        absorb_len_d = (state_d == S_ABSORB) ? len_d : 8'd0;
        pad_en_d     = ((state_d == S_ABSORB) && padded_d) || (state_d == S_PAD);
        pad_pos_d    = ((state_d == S_ABSORB) && padded_d) ? len_d : 8'd0;
        perm_start_d = (state_d == S_PSTART);
        out_valid_d  = (state_d == S_SQUEEZE);
        out_len_d    = '0;
        out_last_d   = 1'b0;
        if (state_d == S_SQUEEZE) begin
            out_len_d  = (rem_d < REM_W'(rate_bits_d)) ? OLEN_W'(rem_d) : rate_bits_d;
            out_last_d = (rem_d <= REM_W'(rate_bits_d));
        end
        domain_d = act_d ? (mode_d[1] ? DS_SHA3 : DS_SHAKE) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            rate_q       <= '0;
            rem_q        <= '0;
            len_q        <= '0;
            last_q       <= 1'b0;
            padded_q     <= 1'b0;
            sqp_q        <= 1'b0;
            act_q        <= 1'b0;
            cmd_ready_o  <= 1'b0;
            blk_ready_o  <= 1'b0;
            state_clr_o  <= 1'b0;
            absorb_en_o  <= 1'b0;
            absorb_len_o <= '0;
            pad_en_o     <= 1'b0;
            pad_pos_o    <= '0;
            domain_o     <= '0;
            rate_bytes_o <= '0;
            perm_start_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_len_o    <= '0;
            out_last_o   <= 1'b0;
            mode_out_o   <= '0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            rate_q       <= rate_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            last_q       <= last_d;
            padded_q     <= padded_d;
            sqp_q        <= sqp_d;
            act_q        <= act_d;
            cmd_ready_o  <= cmd_ready_d;
            blk_ready_o  <= blk_ready_d;
            state_clr_o  <= state_clr_d;
            absorb_en_o  <= absorb_en_d;
            absorb_len_o <= absorb_len_d;
            pad_en_o     <= pad_en_d;
            pad_pos_o    <= pad_pos_d;
            domain_o     <= domain_d;
            rate_bytes_o <= rate_d;
            perm_start_o <= perm_start_d;
            out_valid_o  <= out_valid_d;
            out_len_o    <= out_len_d;
            out_last_o   <= out_last_d;
            mode_out_o   <= mode_d;
            err_o        <= err_d;
        end
    end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Directed bench for sha3_sponge_ctrl: SHA3/SHAKE flows, full-block padding,
// oversize block error, squeeze back-pressure and mid-operation reset.
module tb_sha3_sponge_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_mode;
    logic [12:0] cmd_out_len;
    logic        blk_valid, blk_ready;
    logic [7:0]  blk_len;
    logic        blk_last;
    logic        state_clr, absorb_en, pad_en, perm_start, perm_done;
    logic [7:0]  absorb_len, pad_pos, domain, rate_bytes;
    logic        out_valid, out_ready, out_last, err;
    logic [10:0] out_len;
    logic [1:0]  mode_out;

    int errors = 0;
    int checks = 0;
    int n_perm = 0;
    int base;

    always #5 clk = ~clk;

    sha3_sponge_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_mode_i(cmd_mode), .cmd_out_len_i(cmd_out_len),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
        .blk_len_i(blk_len), .blk_last_i(blk_last),
        .state_clr_o(state_clr), .absorb_en_o(absorb_en), .absorb_len_o(absorb_len),
        .pad_en_o(pad_en), .pad_pos_o(pad_pos), .domain_o(domain),
        .rate_bytes_o(rate_bytes), .perm_start_o(perm_start), .perm_done_i(perm_done),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_len_o(out_len),
        .out_last_o(out_last), .mode_out_o(mode_out), .err_o(err)
    );

    always @(negedge clk) if (perm_start) n_perm++;

    function automatic logic [63:0] all_outs();
        return {10'd0, cmd_ready, blk_ready, state_clr, absorb_en, absorb_len, pad_en,
                pad_pos, domain, rate_bytes, perm_start, out_valid, out_len, out_last,
                mode_out, err};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command once cmd_ready is up; leaves the bench in the first WAIT_BLK cycle
    task automatic send_cmd(input logic [1:0] m, input logic [12:0] olen,
                            input logic [7:0] exp_dom, input logic [7:0] exp_rate);
        int n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_mode = m; cmd_out_len = olen; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("state_clr", 64'(state_clr), 64'd1);
        chk("cmd_ready_clr", 64'(cmd_ready), 64'd0);
        chk("domain", 64'(domain), 64'(exp_dom));
        chk("rate_bytes", 64'(rate_bytes), 64'(exp_rate));
        chk("mode_out", 64'(mode_out), 64'(m));
        tick();
        chk("blk_ready", 64'(blk_ready), 64'd1);
    endtask

    task automatic send_blk(input logic [7:0] len, input logic last);
        blk_len = len; blk_last = last; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic chk_absorb(input string tag, input logic [7:0] len,
                              input logic pe, input logic [7:0] pp);
        chk({tag, "_absorb_en"}, 64'(absorb_en), 64'd1);
        chk({tag, "_absorb_len"}, 64'(absorb_len), 64'(len));
        chk({tag, "_pad_en"}, 64'(pad_en), 64'(pe));
        chk({tag, "_pad_pos"}, 64'(pad_pos), 64'(pp));
        tick();
        chk({tag, "_perm_start"}, 64'(perm_start), 64'd1);
    endtask

    // Called in the perm_start cycle; returns in the cycle after perm_done
    task automatic do_perm();
        tick();
        tick();
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
    endtask

    task automatic take_beat(input string tag, input logic [10:0] len, input logic last);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_out_len"}, 64'(out_len), 64'(len));
        chk({tag, "_out_last"}, 64'(out_last), 64'(last));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic sha3_256_one(input string tag);
        base = n_perm;
        send_cmd(2'b10, 13'd0, 8'h06, 8'd136);
        send_blk(8'd3, 1'b1);
        chk_absorb(tag, 8'd3, 1'b1, 8'd3);
        do_perm();
        take_beat(tag, 11'd256, 1'b1);
        chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
        chk({tag, "_perm_count"}, 64'(n_perm - base), 64'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_out_len = '0;
        blk_valid = 1'b0; blk_len = '0; blk_last = 1'b0;
        perm_done = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // SHA3-256 single short block
        sha3_256_one("t1");

        // SHA3-512 full-rate last block needs a separate pad absorb
        base = n_perm;
        send_cmd(2'b11, 13'd0, 8'h06, 8'd72);
        send_blk(8'd72, 1'b1);
        chk_absorb("t2a", 8'd72, 1'b0, 8'd0);
        do_perm();
        chk_absorb("t2pad", 8'd0, 1'b1, 8'd0);
        do_perm();
        take_beat("t2", 11'd512, 1'b1);
        chk("t2_perm_count", 64'(n_perm - base), 64'd2);

        // SHAKE128 3000 bits -> 1344, 1344, 312
        base = n_perm;
        send_cmd(2'b00, 13'd3000, 8'h1F, 8'd168);
        send_blk(8'd10, 1'b1);
        chk_absorb("t3", 8'd10, 1'b1, 8'd10);
        do_perm();
        take_beat("t3b1", 11'd1344, 1'b0);
        chk("t3_restart", 64'(perm_start), 64'd1);
        do_perm();
        take_beat("t3b2", 11'd1344, 1'b0);
        chk("t3_restart2", 64'(perm_start), 64'd1);
        do_perm();
        take_beat("t3b3", 11'd312, 1'b1);
        chk("t3_perm_count", 64'(n_perm - base), 64'd3);

        // SHA3-512 oversize block is dropped with err
        send_cmd(2'b11, 13'd0, 8'h06, 8'd72);
        send_blk(8'd80, 1'b1);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_no_absorb", 64'(absorb_en), 64'd0);
        chk("t4_blk_ready", 64'(blk_ready), 64'd1);
        tick();
        chk("t4_err_pulse", 64'(err), 64'd0);
        chk("t4_blk_ready2", 64'(blk_ready), 64'd1);
        send_blk(8'd5, 1'b1);
        chk_absorb("t4", 8'd5, 1'b1, 8'd5);
        do_perm();
        take_beat("t4", 11'd512, 1'b1);

        // SHAKE256 2000 bits with consumer stalled on the first beat
        send_cmd(2'b01, 13'd2000, 8'h1F, 8'd136);
        send_blk(8'd20, 1'b1);
        chk_absorb("t5", 8'd20, 1'b1, 8'd20);
        do_perm();
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_valid", 64'(out_valid), 64'd1);
            chk("t5_stall_len", 64'(out_len), 64'd1088);
            tick();
        end
        take_beat("t5b1", 11'd1088, 1'b0);
        do_perm();
        take_beat("t5b2", 11'd912, 1'b1);

        // Reset while waiting on the permutation; late perm_done must be ignored
        send_cmd(2'b10, 13'd0, 8'h06, 8'd136);
        send_blk(8'd3, 1'b1);
        chk_absorb("t6", 8'd3, 1'b1, 8'd3);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        tick();
        chk("t6_idle", 64'(cmd_ready), 64'd1);
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        chk("t6_late_done_valid", 64'(out_valid), 64'd0);
        chk("t6_late_done_idle", 64'(cmd_ready), 64'd1);
        tick();
        chk("t6_quiet", all_outs(), {10'd0, 1'b1, 53'd0});
        sha3_256_one("t6r");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_sponge_ctrl.md
Name: sha3_sponge_ctrl

Overview:
- Control sequencer for the Keccak-f[1600] sponge datapath. Owns no state bits itself.
- Accepts a per-message command (mode, output length) and a stream of input blocks.
- Drives the state clear, absorb/XOR, pad-byte and permutation-start controls.
- Issues output-block beats until the requested digest/XOF length is produced.

Parameters:
R_SHAKE128, 168, rate in bytes for mode 2'b00
R_SHAKE256, 136, rate in bytes for mode 2'b01
R_SHA3_256, 136, rate in bytes for mode 2'b10
R_SHA3_512, 72, rate in bytes for mode 2'b11
DS_SHAKE, 8'h1F, domain/pad byte for SHAKE modes
DS_SHA3, 8'h06, domain/pad byte for SHA3 modes

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  new message command
cmd_ready  out  1  high only in IDLE
cmd_mode  in  2  00 SHAKE128, 01 SHAKE256, 10 SHA3-256, 11 SHA3-512
cmd_out_len  in  13  requested output bits (SHAKE only; ignored for SHA3)
blk_valid  in  1  input block available
blk_ready  out  1  high only in WAIT_BLK
blk_len  in  8  valid bytes in block, 0..rate
blk_last  in  1  final block of message
state_clr  out  1  one-cycle pulse: zero sponge state
absorb_en  out  1  one-cycle pulse: XOR block into state
absorb_len  out  8  bytes to XOR (valid with absorb_en)
pad_en  out  1  apply padding in this absorb
pad_pos  out  8  byte index for domain byte; 0x80 always at rate-1
domain  out  8  DS_SHAKE or DS_SHA3 per latched mode
rate_bytes  out  8  rate of latched mode
perm_start  out  1  one-cycle pulse to permutation core
perm_done  in  1  core completion pulse
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_len  out  11  valid bits in beat
out_last  out  1  final beat
mode_out  out  2  latched mode
err  out  1  one-cycle pulse: blk_len > rate, block dropped

Behaviour:
- Reset: all outputs 0 (cmd_ready=0 while rst high); state→IDLE. Reset mid-operation abandons the message; no partial beats are issued afterwards.
- States: IDLE, CLR, WAIT_BLK, ABSORB, PSTART, PWAIT, PAD, SQUEEZE.
- IDLE: cmd_ready=1. On cmd_valid:
  - Latch mode and rate.
  - Set remaining bits (13-bit): SHAKE = cmd_out_len; SHA3-256 = 256; SHA3-512 = 512.
  - Next state CLR.
- CLR: state_clr=1 for one cycle, then WAIT_BLK.
- WAIT_BLK: blk_ready=1. On handshake:
  - If blk_len > rate: err pulse next cycle, stay in WAIT_BLK.
  - Otherwise latch len/last, go to ABSORB.
- ABSORB: absorb_en=1, absorb_len=latched len.
  - pad_en=1, pad_pos=len only if last and len<rate.
  - Next state PSTART.
- PSTART: perm_start=1 for one cycle, then PWAIT.
- PWAIT: wait for perm_done; perm_done in any other state is ignored. On perm_done, in priority order:
  - Squeeze pending → SQUEEZE.
  - Last absorbed with padding → SQUEEZE.
  - Last absorbed, full block (len==rate, unpadded) → PAD.
  - Otherwise → WAIT_BLK.
- PAD: absorb_en=1, absorb_len=0, pad_en=1, pad_pos=0; then PSTART.
- SQUEEZE:
  - out_valid=1, out_len=min(remaining, rate*8), out_last=(remaining ≤ rate*8). out_len max is 1344, which fits in 11 bits.
  - Outputs hold stable until out_ready.
  - On handshake: remaining -= out_len. If out_last → IDLE; else set squeeze-pending → PSTART.
- SHAKE with cmd_out_len=0: after absorption, a single beat with out_len=0, out_last=1.
- Latency, with block accepted at cycle T:
  - absorb_en at T+1, perm_start at T+2.
  - perm_done at T+2+N; next blk_ready or out_valid at T+3+N.
- Command-to-first-blk_ready: 2 cycles (CLR).

Test Plan:
- SHA3-256, one block blk_len=3, last → absorb_en with pad_en, pad_pos=3, domain=06; 1 perm_start; one beat out_len=256, out_last=1; cmd_ready next cycle.
- SHA3-512, blk_len=72, last → absorb (no pad), perm, PAD absorb (len 0, pad_pos 0), perm; beat out_len=512, out_last=1; exactly 2 perm_start.
- SHAKE128, cmd_out_len=3000, blk_len=10 last → beats 1344, 1344, 312 (last on third); perm_start count 3.
- SHA3-512, blk_len=80 → err pulse, no absorb_en, blk_ready stays 1; next blk_len=5 last proceeds normally.
- out_ready held low 5 cycles in SHAKE256 (cmd_out_len=2000) → out_valid, out_len=1088 stable; second beat 912, out_last=1.
- rst asserted in PWAIT → next cycle all outputs 0, IDLE; late perm_done ignored; new SHA3-256 command completes correctly.
